// File: rtl/spmmio_sdblk.sv
// SD SPI block sequencer: moves one 512-byte block between card and sector buffer via the byte engine.
// Latency: 1 issue cycle + engine time per byte, plus 1 buffer-read cycle per written data byte.
// Backpressure: stalls on the engine busy flag; start is ignored while a transfer is active.
module spmmio_sdblk #(
    parameter int TOKEN_TRIES = 4095,
    parameter int BUSY_TRIES  = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        dir_wr,
    output logic        active,
    output logic        done,
    output logic [2:0]  err,
    output logic [3:0]  m_adr,
    output logic        m_cs,
    output logic [0:3]  m_sel,
    output logic        m_we,
    output logic [0:31] m_d,
    input  logic [0:31] m_q,
    output logic [8:0]  buf_adr,
    output logic        buf_we,
    output logic [7:0]  buf_wdata,
    input  logic [7:0]  buf_rdata
);

    localparam logic [15:0] TOK_LIM  = TOKEN_TRIES[15:0];
    localparam logic [15:0] BUSY_LIM = BUSY_TRIES[15:0];
    localparam logic [9:0]  LAST_IDX = 10'd511;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_HUNT,
        S_RD_CLR,
        S_RD_DATA,
        S_RD_CRC,
        S_RD_CHK,
        S_WR_TOK,
        S_WR_CLR,
        S_WR_DATA,
        S_WR_CRC,
        S_WR_RESP,
        S_WR_BUSY
    } state_t;

    // Per-byte sub-phase; PH_ADDR is the pre-byte cycle (buffer read or CRC read).
    typedef enum logic [1:0] {
        PH_ADDR,
        PH_ISSUE,
        PH_SKIP,
        PH_POLL
    } phase_t;

    state_t      state, state_n;
    phase_t      ph, ph_n;
    logic [9:0]  idx, idx_n;
    logic [15:0] tries, tries_n;
    logic [2:0]  err_n;
    logic        done_n;
    logic [0:15] crc_l, crc_n;

    logic        byte_st;
    logic        byte_done;
    logic        wait_b;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_byte;
    logic        unused_q;

    assign unused_q = &{1'b0, m_q[0:15]};
    assign rx_byte  = m_q[24:31];
    assign active   = (state != S_IDLE);
    assign buf_adr  = idx[8:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            ph    <= PH_ISSUE;
            idx   <= '0;
            tries <= '0;
            err   <= '0;
            done  <= 1'b0;
            crc_l <= '0;
        end else begin
            state <= state_n;
            ph    <= ph_n;
            idx   <= idx_n;
            tries <= tries_n;
            err   <= err_n;
            done  <= done_n;
            crc_l <= crc_n;
        end
    end

    always_comb begin
        byte_st = 1'b0;
        case (state)
            S_RD_HUNT, S_RD_DATA, S_RD_CRC,
            S_WR_TOK, S_WR_RESP, S_WR_BUSY: byte_st = 1'b1;
            S_WR_DATA, S_WR_CRC:            byte_st = (ph != PH_ADDR);
            default:                        byte_st = 1'b0;
        endcase
    end

    // The cycle right after issue is never sampled: the engine's busy flag lags by one cycle.
    assign byte_done = byte_st && (ph == PH_POLL) && !m_q[23];
    assign wait_b    = (state == S_RD_HUNT) || (state == S_WR_RESP);

    always_comb begin
        tx_byte = 8'hFF;
        case (state)
            S_WR_TOK:  tx_byte = 8'hFE;
            S_WR_DATA: tx_byte = buf_rdata;
            S_WR_CRC:  tx_byte = idx[0] ? crc_l[8:15] : crc_l[0:7];
            default:   tx_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_n   = state;
        ph_n      = ph;
        idx_n     = idx;
        tries_n   = tries;
        err_n     = err;
        crc_n     = crc_l;
        done_n    = 1'b0;
        m_adr     = 4'd0;
        m_cs      = 1'b0;
        m_sel     = 4'b0000;
        m_we      = 1'b0;
        m_d       = '0;
        buf_we    = 1'b0;
        buf_wdata = 8'h00;

        if (byte_st) begin
            m_cs = 1'b1;
            case (ph)
                PH_ISSUE: begin
                    m_we        = 1'b1;
                    m_sel       = 4'b0011;
                    m_d[19]     = 1'b1;
                    m_d[22]     = wait_b;
                    m_d[23]     = 1'b1;
                    m_d[24:31]  = tx_byte;
                    ph_n        = PH_SKIP;
                end
                PH_SKIP: ph_n = PH_POLL;
                PH_POLL: if (byte_done) ph_n = PH_ISSUE;
                default: ph_n = PH_ISSUE;
            endcase
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    err_n   = 3'b000;
                    idx_n   = '0;
                    tries_n = '0;
                    ph_n    = PH_ISSUE;
                    state_n = dir_wr ? S_WR_TOK : S_RD_HUNT;
                end
            end
            S_RD_HUNT: begin
                if (byte_done) begin
                    if (rx_byte == 8'hFE) begin
                        state_n = S_RD_CLR;
                    end else if (rx_byte == 8'hFF) begin
                        if (tries == TOK_LIM) begin
                            err_n[2] = 1'b1;
                            state_n  = S_IDLE;
                            done_n   = 1'b1;
                        end else begin
                            tries_n = tries + 16'd1;
                        end
                    end else begin
                        err_n[0] = 1'b1;
                        state_n  = S_IDLE;
                        done_n   = 1'b1;
                    end
                end
            end
            S_RD_CLR: begin
                m_cs    = 1'b1;
                m_adr   = 4'd1;
                m_we    = 1'b1;
                m_sel   = 4'b0011;
                m_d[31] = 1'b0;
                idx_n   = '0;
                ph_n    = PH_ISSUE;
                state_n = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (byte_done) begin
                    buf_we    = 1'b1;
                    buf_wdata = rx_byte;
                    if (idx == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = S_RD_CRC;
                    end else begin
                        idx_n = idx + 10'd1;
                    end
                end
            end
            S_RD_CRC: begin
                if (byte_done) begin
                    if (idx[0]) state_n = S_RD_CHK;
                    else        idx_n   = idx + 10'd1;
                end
            end
            S_RD_CHK: begin
                // CRC over data plus received CRC leaves a zero residue when intact.
                m_cs  = 1'b1;
                m_adr = 4'd1;
                if (m_q[16:31] != 16'h0000) err_n[1] = 1'b1;
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
            S_WR_TOK: begin
                if (byte_done) state_n = S_WR_CLR;
            end
            S_WR_CLR: begin
                m_cs    = 1'b1;
                m_adr   = 4'd1;
                m_we    = 1'b1;
                m_sel   = 4'b0011;
                m_d[31] = 1'b1;
                idx_n   = '0;
                ph_n    = PH_ADDR;
                state_n = S_WR_DATA;
            end
            S_WR_DATA: begin
                if (ph == PH_ADDR) begin
                    ph_n = PH_ISSUE;
                end else if (byte_done) begin
                    ph_n = PH_ADDR;
                    if (idx == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = S_WR_CRC;
                    end else begin
                        idx_n = idx + 10'd1;
                    end
                end
            end
            S_WR_CRC: begin
                if (ph == PH_ADDR) begin
                    m_cs  = 1'b1;
                    m_adr = 4'd1;
                    crc_n = m_q[16:31];
                    ph_n  = PH_ISSUE;
                end else if (byte_done) begin
                    if (idx[0]) begin
                        tries_n = '0;
                        state_n = S_WR_RESP;
                    end else begin
                        idx_n = idx + 10'd1;
                    end
                end
            end
            S_WR_RESP: begin
                if (byte_done) begin
                    if (rx_byte[4:0] != 5'b00101) begin
                        err_n[0] = 1'b1;
                        state_n  = S_IDLE;
                        done_n   = 1'b1;
                    end else begin
                        tries_n = '0;
                        state_n = S_WR_BUSY;
                    end
                end
            end
            S_WR_BUSY: begin
                if (byte_done) begin
                    if (rx_byte != 8'h00) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else if (tries == BUSY_LIM) begin
                        err_n[2] = 1'b1;
                        state_n  = S_IDLE;
                        done_n   = 1'b1;
                    end else begin
                        tries_n = tries + 16'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spmmio_sdblk.sv
// Bench for spmmio_sdblk: byte-engine/card/buffer models plus a block-level reference model.
module tb_spmmio_sdblk;

    localparam int TOK = 8;
    localparam int BSY = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        dir_wr = 1'b0;
    logic        active, done;
    logic [2:0]  err;
    logic [3:0]  m_adr;
    logic        m_cs, m_we;
    logic [0:3]  m_sel;
    logic [0:31] m_d;
    logic [0:31] m_q;
    logic [8:0]  buf_adr;
    logic        buf_we;
    logic [7:0]  buf_wdata;
    logic [7:0]  buf_rdata = 8'h00;

    always #5 clk = ~clk;

    spmmio_sdblk #(.TOKEN_TRIES(TOK), .BUSY_TRIES(BSY)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dir_wr(dir_wr),
        .active(active), .done(done), .err(err),
        .m_adr(m_adr), .m_cs(m_cs), .m_sel(m_sel), .m_we(m_we), .m_d(m_d), .m_q(m_q),
        .buf_adr(buf_adr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata)
    );

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // Engine / card / buffer model state
    logic        pend = 1'b0, busy = 1'b0, crc_mosi = 1'b0;
    int          cnt = 0, lat = 0;
    logic [7:0]  rdat = 8'hFF, res = 8'hFF;
    logic [15:0] eng_crc = 16'h0000;
    int          issue_cnt = 0, bw_cnt = 0, done_cnt = 0, proto_viol = 0, fmt_viol = 0;
    logic [7:0]  mosi_log [0:8191];
    logic        wait_log [0:8191];
    logic [7:0]  card_mem [0:1023];
    int          card_len = 0, card_base = 0;
    logic [7:0]  wmem [0:511];
    logic [7:0]  rmem [0:511];
    int          rtag [0:511];
    int          cur_tag = 0;

    assign m_q = (m_adr == 4'd1) ? {16'h0000, eng_crc} : {23'd0, busy, rdat};

    always @(posedge clk) begin : engine
        logic [7:0] b;
        int k;
        if (pend) begin
            pend <= 1'b0;
            busy <= 1'b1;
            cnt  <= lat;
        end else if (busy) begin
            if (cnt == 0) begin
                busy <= 1'b0;
                rdat <= res;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (m_cs && m_we && m_adr == 4'd0) begin
            if (pend || busy) proto_viol <= proto_viol + 1;
            if (m_sel != 4'b0011 || !m_d[19] || !m_d[23] || m_d[0:18] != 19'd0 || m_d[20:21] != 2'd0)
                fmt_viol <= fmt_viol + 1;
            k = issue_cnt - card_base;
            b = (k >= 0 && k < card_len) ? card_mem[k] : 8'hFF;
            res  <= b;
            pend <= 1'b1;
            lat  <= $urandom_range(0, 2);
            mosi_log[issue_cnt % 8192] <= m_d[24:31];
            wait_log[issue_cnt % 8192] <= m_d[22];
            eng_crc   <= crc_upd(eng_crc, crc_mosi ? m_d[24:31] : b);
            issue_cnt <= issue_cnt + 1;
        end else if (m_cs && m_we && m_adr == 4'd1) begin
            if (m_sel != 4'b0011) fmt_viol <= fmt_viol + 1;
            eng_crc  <= 16'h0000;
            crc_mosi <= m_d[31];
        end
        buf_rdata <= wmem[buf_adr];
        if (buf_we) begin
            rmem[buf_adr] <= buf_wdata;
            rtag[buf_adr] <= cur_tag;
            bw_cnt <= bw_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic       dir;
        int         lead;
        logic [7:0] tok;
        logic       flip;
        logic [7:0] resp;
        int         zeros;
        int         pat;
        logic [2:0] exp_err;
    } vec_t;

    vec_t       vecs [0:9];
    logic [7:0] dat [0:512];
    logic [7:0] exp_mosi [0:1023];
    logic       exp_wait [0:1023];
    int         exp_iss, exp_bw, iss0, bw0, dn0;
    int         checks = 0, failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setup_row(input vec_t v);
        int n, nh;
        logic [15:0] c;
        logic ok, tmo;
        cur_tag = cur_tag + 1;
        card_base = issue_cnt;
        iss0 = issue_cnt;
        bw0  = bw_cnt;
        dn0  = done_cnt;
        for (int i = 0; i < 512; i++)
            dat[i] = (v.pat == 0) ? 8'(i) : (v.pat == 1) ? 8'(~i) : 8'($urandom);
        c = 16'h0000;
        for (int i = 0; i < 512; i++) c = crc_upd(c, dat[i]);
        n = 0;
        if (!v.dir) begin
            if (v.tok != 8'hFF) begin
                for (int i = 0; i < v.lead; i++) begin card_mem[n] = 8'hFF; n++; end
                card_mem[n] = v.tok; n++;
                for (int i = 0; i < 512; i++) begin card_mem[n] = dat[i]; n++; end
                card_mem[n] = c[15:8]; n++;
                card_mem[n] = c[7:0] ^ {7'd0, v.flip}; n++;
            end
            card_len = n;
            // Reference: hunt bytes counted in FF results, then token, data, CRC.
            tmo = (v.tok == 8'hFF) || (v.lead > TOK);
            nh  = tmo ? TOK + 1 : v.lead + 1;
            exp_iss = (tmo || v.tok != 8'hFE) ? nh : nh + 514;
            exp_bw  = (tmo || v.tok != 8'hFE) ? 0 : 512;
            for (int j = 0; j < 1024; j++) begin
                exp_mosi[j] = 8'hFF;
                exp_wait[j] = (j < nh);
            end
        end else begin
            for (int i = 0; i < 515; i++) begin card_mem[n] = 8'hFF; n++; end
            card_mem[n] = v.resp; n++;
            for (int i = 0; i < v.zeros; i++) begin card_mem[n] = 8'h00; n++; end
            card_mem[n] = 8'hFF; n++;
            card_len = n;
            for (int i = 0; i < 512; i++) wmem[i] = dat[i];
            ok = (v.resp[4:0] == 5'b00101);
            exp_iss = 516 + (!ok ? 0 : (v.zeros > BSY) ? BSY + 1 : v.zeros + 1);
            exp_bw = 0;
            for (int j = 0; j < 1024; j++) begin
                exp_mosi[j] = 8'hFF;
                exp_wait[j] = (j == 515);
            end
            exp_mosi[0] = 8'hFE;
            for (int i = 0; i < 512; i++) exp_mosi[1 + i] = dat[i];
            exp_mosi[513] = c[15:8];
            exp_mosi[514] = c[7:0];
        end
    endtask

    task automatic run_row(input int r, input vec_t v, input logic poke);
        int t, mm, wm, bm;
        setup_row(v);
        @(negedge clk);
        dir_wr = v.dir;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        dir_wr = 1'b0;
        @(negedge clk);
        check($sformatf("row%0d_err_cleared", r), int'(err), 0);
        check($sformatf("row%0d_active", r), int'(active), 1);
        if (poke) begin
            repeat (40) @(negedge clk);
            dir_wr = ~v.dir;
            start  = 1'b1;
            @(negedge clk);
            start  = 1'b0;
            dir_wr = 1'b0;
        end
        t = 0;
        while (done_cnt == dn0 && t < 10000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("row%0d_done_seen", r), int'(done_cnt != dn0), 1);
        repeat (3) @(negedge clk);
        check($sformatf("row%0d_done_once", r), done_cnt - dn0, 1);
        check($sformatf("row%0d_err", r), int'(err), int'(v.exp_err));
        check($sformatf("row%0d_idle", r), int'(active), 0);
        check($sformatf("row%0d_issues", r), issue_cnt - iss0, exp_iss);
        check($sformatf("row%0d_buf_writes", r), bw_cnt - bw0, exp_bw);
        mm = 0;
        wm = 0;
        for (int j = 0; j < exp_iss && j < 1024; j++) begin
            if (mosi_log[(iss0 + j) % 8192] != exp_mosi[j]) mm++;
            if (wait_log[(iss0 + j) % 8192] != exp_wait[j]) wm++;
        end
        check($sformatf("row%0d_mosi_mismatches", r), mm, 0);
        check($sformatf("row%0d_wait_mismatches", r), wm, 0);
        if (exp_bw == 512) begin
            bm = 0;
            for (int i = 0; i < 512; i++)
                if (rtag[i] != cur_tag || rmem[i] != dat[i]) bm++;
            check($sformatf("row%0d_buffer_mismatches", r), bm, 0);
        end
    endtask

    initial begin : main
        int t, dn_snap;
        vecs[0] = '{1'b0, 3, 8'hFE, 1'b0, 8'h00, 0,  0, 3'b000};
        vecs[1] = '{1'b0, 3, 8'hFE, 1'b1, 8'h00, 0,  0, 3'b010};
        vecs[2] = '{1'b0, 3, 8'hFC, 1'b0, 8'h00, 0,  0, 3'b001};
        vecs[3] = '{1'b0, 0, 8'hFF, 1'b0, 8'h00, 0,  0, 3'b100};
        vecs[4] = '{1'b0, 8, 8'hFE, 1'b0, 8'h00, 0,  2, 3'b000};
        vecs[5] = '{1'b0, 9, 8'hFE, 1'b0, 8'h00, 0,  2, 3'b100};
        vecs[6] = '{1'b1, 0, 8'h00, 1'b0, 8'hE5, 5,  1, 3'b000};
        vecs[7] = '{1'b1, 0, 8'h00, 1'b0, 8'hEB, 5,  1, 3'b001};
        vecs[8] = '{1'b1, 0, 8'h00, 1'b0, 8'hE5, 21, 2, 3'b100};
        vecs[9] = '{1'b1, 0, 8'h00, 1'b0, 8'hE5, 20, 2, 3'b000};
        for (int i = 0; i < 512; i++) wmem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_active_done_err", int'({active, done, err}), 0);
        check("reset_mbus", int'({m_cs, m_we, m_sel, m_adr}), 0);
        check("reset_m_d", int'(m_d), 0);
        check("reset_buf", int'({buf_we, buf_adr}), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 10; r++) run_row(r, vecs[r], 1'b0);

        // Async reset in the middle of the read data phase.
        setup_row(vecs[0]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (bw_cnt - bw0 < 200 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("midrst_reached_byte200", int'(bw_cnt - bw0 >= 200), 1);
        dn_snap = done_cnt;
        #1 reset_n = 1'b0;
        #1;
        check("midrst_active_done_err", int'({active, done, err}), 0);
        check("midrst_mbus", int'({m_cs, m_we, m_sel, m_adr}), 0);
        check("midrst_m_d", int'(m_d), 0);
        check("midrst_buf", int'({buf_we, buf_adr}), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_done", done_cnt - dn_snap, 0);
        check("midrst_idle", int'(active), 0);

        // Clean read after the abort, with a start pulse injected mid-transfer.
        run_row(10, vecs[0], 1'b1);

        check("engine_overlap_issues", proto_viol, 0);
        check("engine_format_errors", fmt_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
